// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory init sink.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int          DEPTH_WORDS_DEF = 64;
    localparam logic [31:0] NOP             = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// Word storage with a per-word written bit, one write port and a registered read port.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int XLEN        = 32,
    localparam int IW         = $clog2(DEPTH_WORDS)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            wr_en_i,
    input  logic            wr_clr_i,
    input  logic [IW-1:0]   wr_idx_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic            wr_new_o,
    input  logic            rd_en_i,
    input  logic            rd_zero_i,
    input  logic [IW-1:0]   rd_idx_i,
    output logic [XLEN-1:0] rd_data_o
);

    logic [XLEN-1:0]        mem_q [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] written_q;
    logic [DEPTH_WORDS-1:0] written_d;
    logic [XLEN-1:0]        rd_data_q;

    // A clear on the same edge makes every word look fresh to this write.
    assign wr_new_o = wr_en_i && (wr_clr_i || !written_q[wr_idx_i]);

    always_comb begin
        written_d = wr_clr_i ? '0 : written_q;
        if (wr_en_i) begin
            written_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            written_q <= '0;
            rd_data_q <= XLEN'(NOP);
        end else begin
            if (wr_en_i) begin
                mem_q[wr_idx_i] <= wr_data_i;
            end
            written_q <= written_d;
            if (rd_zero_i) begin
                rd_data_q <= XLEN'(NOP);
            end else if (rd_en_i) begin
                rd_data_q <= mem_q[rd_idx_i];
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_init_sink.sv
// Instruction memory loaded through an init write port, then fetched in RUN
// with one-cycle latency; reports distinct-word count and sticky address errors.
module imem_init_sink
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int XLEN        = 32,
    localparam int IW         = $clog2(DEPTH_WORDS),
    localparam int CW         = IW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            initialize,
    input  logic [XLEN-1:0] instruction_initialize_data,
    input  logic [XLEN-1:0] instruction_initialize_address,
    input  logic            fetch_en,
    input  logic [XLEN-1:0] fetch_addr,
    output logic [XLEN-1:0] instruction,
    output logic            fetch_valid,
    output logic            init_done,
    output logic [CW-1:0]   init_word_count,
    output logic            align_err,
    output logic            range_err
);

    localparam logic [XLEN-1:0] BYTE_LIMIT = XLEN'(4 * DEPTH_WORDS);

    state_e        state_q, state_d;
    logic          fetch_valid_q, init_done_q, align_err_q, range_err_q;
    logic [CW-1:0] count_q, count_d;
    logic          align_d, range_d;
    logic          w_aligned, w_inrange, f_aligned, f_inrange;
    logic          enter_load, wr_ok, wr_new, fetch_go, rd_en, rd_zero;

    assign w_aligned = (instruction_initialize_address[1:0] == 2'b00);
    assign w_inrange = (instruction_initialize_address < BYTE_LIMIT);
    assign f_aligned = (fetch_addr[1:0] == 2'b00);
    assign f_inrange = (fetch_addr < BYTE_LIMIT);

    always_comb begin
        state_d = state_q;
        if (initialize) begin
            state_d = LOAD;
        end else if (state_q == LOAD) begin
            state_d = RUN;
        end
        enter_load = initialize && (state_q != LOAD);
        wr_ok      = initialize && w_aligned && w_inrange;
        fetch_go   = (state_q == RUN) && fetch_en && !initialize;
        rd_en      = fetch_go && f_aligned && f_inrange;
        // Instruction reads zero whenever not in RUN and on any bad fetch.
        rd_zero    = (state_d != RUN) || (fetch_go && !(f_aligned && f_inrange));

        align_d = enter_load ? 1'b0 : align_err_q;
        range_d = enter_load ? 1'b0 : range_err_q;
        if (initialize && !w_aligned) align_d = 1'b1;
        if (initialize && !w_inrange) range_d = 1'b1;
        if (fetch_go && !f_aligned)   align_d = 1'b1;
        if (fetch_go && !f_inrange)   range_d = 1'b1;

        count_d = enter_load ? '0 : count_q;
        if (wr_new) begin
            count_d = count_d + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            fetch_valid_q <= 1'b0;
            init_done_q   <= 1'b0;
            align_err_q   <= 1'b0;
            range_err_q   <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_go;
            init_done_q   <= (state_d == RUN);
            align_err_q   <= align_d;
            range_err_q   <= range_d;
            count_q       <= count_d;
        end
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .XLEN        (XLEN)
    ) u_array (
        .clk_i     (clk),
        .rst_n_i   (rst),
        .wr_en_i   (wr_ok),
        .wr_clr_i  (enter_load),
        .wr_idx_i  (instruction_initialize_address[IW+1:2]),
        .wr_data_i (instruction_initialize_data),
        .wr_new_o  (wr_new),
        .rd_en_i   (rd_en),
        .rd_zero_i (rd_zero),
        .rd_idx_i  (fetch_addr[IW+1:2]),
        .rd_data_o (instruction)
    );

    assign fetch_valid     = fetch_valid_q;
    assign init_done       = init_done_q;
    assign init_word_count = count_q;
    assign align_err       = align_err_q;
    assign range_err       = range_err_q;

endmodule

// File: tb/tb_imem_init_sink.sv
// Bench for imem_init_sink: directed vector table, corner sequences, then random traffic vs a reference model.
module tb_imem_init_sink;

    localparam int D = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        initialize;
    logic [31:0] idata, iaddr;
    logic        fetch_en;
    logic [31:0] faddr;
    logic [31:0] instruction;
    logic        fetch_valid, init_done, align_err, range_err;
    logic [6:0]  init_word_count;

    int tests = 0;
    int fails = 0;

    imem_init_sink #(.DEPTH_WORDS(D), .XLEN(32)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .initialize                     (initialize),
        .instruction_initialize_data    (idata),
        .instruction_initialize_address (iaddr),
        .fetch_en                       (fetch_en),
        .fetch_addr                     (faddr),
        .instruction                    (instruction),
        .fetch_valid                    (fetch_valid),
        .init_done                      (init_done),
        .init_word_count                (init_word_count),
        .align_err                      (align_err),
        .range_err                      (range_err)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 loading, 2 running.
    int          m_state;
    logic [31:0] m_mem [D];
    bit          m_wr  [D];
    int          m_cnt;
    bit          m_al, m_rg, m_fv;
    logic [31:0] m_ins;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_al = 0; m_rg = 0; m_fv = 0; m_ins = 0;
        for (int i = 0; i < D; i++) begin
            m_mem[i] = 0;
            m_wr[i]  = 0;
        end
    endtask

    task automatic model_step();
        if (initialize) begin
            if (m_state != 1) begin
                for (int i = 0; i < D; i++) m_wr[i] = 0;
                m_cnt = 0; m_al = 0; m_rg = 0;
            end
            if (iaddr % 4 != 0) m_al = 1;
            if (iaddr >= 4 * D) m_rg = 1;
            if (iaddr % 4 == 0 && iaddr < 4 * D) begin
                if (!m_wr[iaddr / 4]) begin
                    m_wr[iaddr / 4] = 1;
                    m_cnt++;
                end
                m_mem[iaddr / 4] = idata;
            end
            m_state = 1; m_fv = 0; m_ins = 0;
        end else if (m_state == 1) begin
            m_state = 2; m_fv = 0; m_ins = 0;
        end else if (m_state == 2) begin
            if (fetch_en) begin
                m_fv = 1;
                if (faddr % 4 != 0 || faddr >= 4 * D) begin
                    if (faddr % 4 != 0) m_al = 1;
                    if (faddr >= 4 * D) m_rg = 1;
                    m_ins = 0;
                end else begin
                    m_ins = m_mem[faddr / 4];
                end
            end else begin
                m_fv = 0;
            end
        end else begin
            m_fv = 0; m_ins = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(bit ini, logic [31:0] d, logic [31:0] a, bit fe, logic [31:0] fa);
        initialize = ini; idata = d; iaddr = a; fetch_en = fe; faddr = fa;
    endtask

    task automatic check(string name, logic [31:0] ei, bit efv, bit edone, int ecnt, bit eal, bit erg);
        tests++;
        if (instruction !== ei || fetch_valid !== efv || init_done !== edone ||
            init_word_count !== 7'(ecnt) || align_err !== eal || range_err !== erg) begin
            fails++;
            $display("FAIL %s: got ins=%h fv=%b done=%b cnt=%0d al=%b rg=%b, expected ins=%h fv=%b done=%b cnt=%0d al=%b rg=%b",
                     name, instruction, fetch_valid, init_done, init_word_count, align_err, range_err,
                     ei, efv, edone, ecnt, eal, erg);
        end
    endtask

    task automatic check_model(string name);
        check(name, m_ins, m_fv, (m_state == 2), m_cnt, m_al, m_rg);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 7)       return 32'($urandom_range(0, 15)) * 4;
        else if (k == 7) return 32'($urandom_range(0, D - 1)) * 4 + 32'($urandom_range(1, 3));
        else if (k == 8) return 32'(4 * D) + 32'($urandom_range(0, 63));
        else             return $urandom;
    endfunction

    typedef struct {
        bit          ini;
        logic [31:0] d;
        logic [31:0] a;
        bit          fe;
        logic [31:0] fa;
        logic [31:0] e_ins;
        bit          e_fv;
        bit          e_done;
        int          e_cnt;
        bit          e_al;
        bit          e_rg;
    } vec_t;

    vec_t vecs [20];

    initial begin
        //              ini  data          addr  fe  faddr  ins           fv done cnt al rg
        vecs[0]  = '{1, 32'h00020820, 0,   0, 0,   32'h0,        0, 0, 1, 0, 0};
        vecs[1]  = '{1, 32'h00020820, 0,   0, 0,   32'h0,        0, 0, 1, 0, 0};
        vecs[2]  = '{1, 32'h00844022, 4,   0, 0,   32'h0,        0, 0, 2, 0, 0};
        vecs[3]  = '{1, 32'h00844022, 4,   0, 0,   32'h0,        0, 0, 2, 0, 0};
        vecs[4]  = '{0, 32'h0,        0,   0, 0,   32'h0,        0, 1, 2, 0, 0};
        vecs[5]  = '{0, 32'h0,        0,   1, 0,   32'h00020820, 1, 1, 2, 0, 0};
        vecs[6]  = '{0, 32'h0,        0,   1, 4,   32'h00844022, 1, 1, 2, 0, 0};
        vecs[7]  = '{0, 32'h0,        0,   0, 0,   32'h00844022, 0, 1, 2, 0, 0};
        vecs[8]  = '{0, 32'h0,        0,   1, 8,   32'h0,        1, 1, 2, 0, 0};
        vecs[9]  = '{0, 32'h0,        0,   1, 6,   32'h0,        1, 1, 2, 1, 0};
        vecs[10] = '{0, 32'h0,        0,   1, 256, 32'h0,        1, 1, 2, 1, 1};
        vecs[11] = '{1, 32'hDEADBEEF, 12,  0, 0,   32'h0,        0, 0, 1, 0, 0};
        vecs[12] = '{1, 32'h11111111, 2,   0, 0,   32'h0,        0, 0, 1, 1, 0};
        vecs[13] = '{1, 32'h22222222, 260, 0, 0,   32'h0,        0, 0, 1, 1, 1};
        vecs[14] = '{0, 32'h0,        0,   0, 0,   32'h0,        0, 1, 1, 1, 1};
        vecs[15] = '{0, 32'h0,        0,   1, 0,   32'h00020820, 1, 1, 1, 1, 1};
        vecs[16] = '{0, 32'h0,        0,   1, 12,  32'hDEADBEEF, 1, 1, 1, 1, 1};
        vecs[17] = '{1, 32'h33333333, 16,  0, 0,   32'h0,        0, 0, 1, 0, 0};
        vecs[18] = '{0, 32'h0,        0,   0, 0,   32'h0,        0, 1, 1, 0, 0};
        vecs[19] = '{0, 32'h0,        0,   1, 16,  32'h33333333, 1, 1, 1, 0, 0};

        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        #12 rst = 1'b1;
        #1;
        check("reset", 32'h0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            set_in(vecs[i].ini, vecs[i].d, vecs[i].a, vecs[i].fe, vecs[i].fa);
            step();
            check($sformatf("vec%0d", i), vecs[i].e_ins, vecs[i].e_fv, vecs[i].e_done,
                  vecs[i].e_cnt, vecs[i].e_al, vecs[i].e_rg);
        end

        // fetch_en held while loading must never produce a valid fetch
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h44444444, 20, 1, 0);
            step();
            check($sformatf("load_fetch%0d", i), 32'h0, 0, 0, 1, 0, 0);
        end
        set_in(0, 0, 0, 1, 20);
        step();
        check("load_to_run", 32'h0, 0, 1, 1, 0, 0);
        set_in(0, 0, 0, 1, 20);
        step();
        check("run_fetch20", 32'h44444444, 1, 1, 1, 0, 0);

        // asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        check("async_rst", 32'h0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(1, 32'h55555555, 20, 0, 0);
        step();
        check_model("fresh_load");
        set_in(0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 1, 0);
        step();
        check("fresh_fetch0", 32'h0, 1, 1, 1, 0, 0);

        for (int n = 0; n < 800; n++) begin
            set_in($urandom_range(0, 9) < 2, $urandom, rand_addr(),
                   $urandom_range(0, 3) != 0, rand_addr());
            step();
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_init_sink.md
IMEM_INIT_SINK -- requirements
Module: imem_init_sink

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit instruction words stored (byte range 0 to 4*DEPTH_WORDS-1).
REQ-002 Parameter XLEN, default 32, width of data and byte-address buses.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port initialize  input  1  load mode request; 1 = accept init writes.
REQ-006 Port instruction_initialize_data  input  XLEN  word to store.
REQ-007 Port instruction_initialize_address  input  XLEN  byte address of word to store.
REQ-008 Port fetch_en  input  1  fetch request.
REQ-009 Port fetch_addr  input  XLEN  byte address to fetch.
REQ-010 Port instruction  output  XLEN  fetched word, registered.
REQ-011 Port fetch_valid  output  1  instruction holds a valid fetch result this cycle.
REQ-012 Port init_done  output  1  high while in RUN.
REQ-013 Port init_word_count  output  clog2(DEPTH_WORDS)+1  distinct words written since last LOAD entry.
REQ-014 Port align_err  output  1  sticky: misaligned init write or fetch seen.
REQ-015 Port range_err  output  1  sticky: out-of-range init write or fetch seen.

Function
REQ-016 States IDLE, LOAD, RUN; IDLE->LOAD and RUN->LOAD when initialize=1; LOAD->RUN when initialize=0; IDLE holds while initialize=0.
REQ-017 Every edge with initialize=1 (any state) is an init write cycle; aligned (addr[1:0]=0) in-range address writes data to word addr[clog2(DEPTH_WORDS)+1:2].
REQ-018 Misaligned init write: dropped, align_err set; out-of-range (addr >= 4*DEPTH_WORDS): dropped, range_err set; both conditions set both flags.
REQ-019 Each word has a written bit; init_word_count increments only when a write hits a word whose bit is clear; repeated writes to the same address (held for multiple cycles) count once, data last-write-wins.
REQ-020 Entering LOAD from IDLE or RUN clears all written bits, init_word_count, align_err, range_err in that same edge; memory contents are retained; that edge's write is applied and counted.
REQ-021 Fetch serviced only in RUN with fetch_en=1: next cycle instruction = stored word, fetch_valid=1; latency exactly one cycle, one fetch per cycle, back-to-back allowed.
REQ-022 Fetch to a never-written word returns 32'h00000000 (NOP).
REQ-023 Misaligned or out-of-range fetch: instruction=0, fetch_valid=1, corresponding sticky flag set.
REQ-024 fetch_en in IDLE or LOAD ignored: fetch_valid=0, instruction=0, no flag change.
REQ-025 fetch_valid=0 and instruction holds its last value in RUN cycles with fetch_en=0.
REQ-026 init_done=1 exactly when state=RUN; deasserts on the edge that enters LOAD.
REQ-027 Init writes and fetches are mutually exclusive by state; no read-during-write forwarding required.

Reset
REQ-028 rst=0 asynchronously forces: state IDLE, instruction=0, fetch_valid=0, init_done=0, init_word_count=0, align_err=0, range_err=0, all written bits 0, all memory words 0.
REQ-029 Reset mid-LOAD or mid-RUN discards all contents; after rst rises, first edge with initialize=1 behaves per REQ-016/REQ-020.

Structure
REQ-030 Shared package imem_pkg holds the state enum (IDLE, LOAD, RUN), DEPTH_WORDS default, and the NOP constant 32'h00000000.
REQ-031 One sub-module imem_array: word storage plus written-bit vector, with write port (en, index, data) returning "was-new" and a registered read port.

Verification
REQ-032 Reset, initialize=1, write 32'h00020820 @0 held 2 cycles, 32'h00844022 @4 held 2 cycles, initialize=0 -> init_word_count=2, init_done=1 next edge.
REQ-033 RUN, fetch_en=1 with addr 0 then 4 back-to-back -> instruction 32'h00020820 then 32'h00844022 on consecutive cycles, fetch_valid=1 both.
REQ-034 RUN, fetch addr 8 (unwritten) -> instruction=0, fetch_valid=1, no flags; fetch addr 6 -> align_err=1; fetch addr 256 -> range_err=1, instruction=0.
REQ-035 Init write @2 and @260 -> both dropped, align_err=1, range_err=1, count unchanged; re-enter LOAD from RUN -> flags and count cleared, word @0 still 32'h00020820.
REQ-036 Assert rst=0 mid-RUN between clock edges -> outputs zero immediately; fetch addr 0 after a fresh empty LOAD/RUN returns 0.
REQ-037 fetch_en=1 during LOAD -> fetch_valid stays 0 throughout.
